// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcode/funct7 constants, ALU op codes, decoded bundle.
package rv_decode_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_ADD  = 3'b000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  // Immediate is carried separately so its width can follow the top-level WIDTH.
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    alu_op_t    alu_op;
    logic       alu_src_imm;
    logic       reg_write;
    logic       illegal;
  } bundle_t;

endpackage

// File: rtl/alu_ctrl.sv
// Combinational ALU control: opcode/funct3/funct7 -> ALU op plus illegal flag.
// Illegal encodings always report ADD so downstream sees a harmless operation.
module alu_ctrl
  import rv_decode_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_t    alu_op_o,
  output logic       illegal_o
);

  alu_op_t base_op;

  always_comb begin
    base_op = ALU_ADD;
    case (funct3_i)
      3'b000: base_op = ALU_ADD;
      3'b001: base_op = ALU_SLL;
      3'b010: base_op = ALU_SLT;
      3'b011: base_op = ALU_SLTU;
      3'b100: base_op = ALU_XOR;
      3'b101: base_op = ALU_SRL;
      3'b110: base_op = ALU_OR;
      3'b111: base_op = ALU_AND;
    endcase
  end

  always_comb begin
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    if (opcode_i == OP_R) begin
      if (funct7_i == F7_BASE) begin
        alu_op_o = base_op;
      end else if (funct7_i == F7_ALT && funct3_i == F3_ADD) begin
        alu_op_o = ALU_SUB;
      end else if (funct7_i == F7_ALT && funct3_i == F3_SR) begin
        alu_op_o = ALU_SRA;
      end else begin
        illegal_o = 1'b1;
      end
    end else if (opcode_i == OP_I) begin
      // Shift-immediates reuse funct7 as a qualifier; everything else ignores it.
      if (funct3_i == F3_SLL || funct3_i == F3_SR) begin
        if (funct7_i == F7_BASE) begin
          alu_op_o = base_op;
        end else if (funct7_i == F7_ALT && funct3_i == F3_SR) begin
          alu_op_o = ALU_SRA;
        end else begin
          illegal_o = 1'b1;
        end
      end else begin
        alu_op_o = base_op;
      end
    end else begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/inst_decode.sv
// RV32I R/I-type decode into a single-entry register; bundle valid one cycle after accept, stalls hold it.
// Halt word (all zero) is swallowed and blocks intake until reset; INST_DECODE_PERF_EN adds perf counters.
module inst_decode
  import rv_decode_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic [31:0]      iInst,
  input  logic             iValid,
  output logic             oReady,
  output logic             oValid,
  input  logic             iReady,
  output logic [4:0]       oRd,
  output logic [4:0]       oRs1,
  output logic [4:0]       oRs2,
  output logic [WIDTH-1:0] oImm,
  output logic [3:0]       oAluOp,
  output logic             oAluSrcImm,
  output logic             oRegWrite,
  output logic             oIllegal,
  output logic             oHalt,
  output logic [31:0]      oInstCount,
  output logic [31:0]      oStallCount
);

  bundle_t          bnd_d, bnd_q;
  logic [WIDTH-1:0] imm_d, imm_q;
  logic             vld_q, halt_q;
  logic             accept, is_halt;
  alu_op_t          ctl_op;
  logic             ctl_ill;

  // Ready is held low while in reset so nothing upstream sees a phantom accept.
  assign oReady  = iRstN && !halt_q && (!vld_q || iReady);
  assign accept  = iValid && oReady;
  assign is_halt = (iInst == 32'h0000_0000);

  alu_ctrl u_alu_ctrl (
    .opcode_i  (iInst[6:0]),
    .funct3_i  (iInst[14:12]),
    .funct7_i  (iInst[31:25]),
    .alu_op_o  (ctl_op),
    .illegal_o (ctl_ill)
  );

  always_comb begin
    bnd_d           = '0;
    imm_d           = '0;
    bnd_d.rd        = iInst[11:7];
    bnd_d.rs1       = iInst[19:15];
    bnd_d.rs2       = iInst[24:20];
    bnd_d.alu_op    = ctl_op;
    bnd_d.illegal   = ctl_ill;
    bnd_d.reg_write = !ctl_ill && (iInst[11:7] != 5'd0);
    if (iInst[6:0] == OP_I) begin
      bnd_d.alu_src_imm = 1'b1;
      if (iInst[14:12] == F3_SLL || iInst[14:12] == F3_SR) begin
        imm_d = {{(WIDTH-5){1'b0}}, iInst[24:20]};
      end else begin
        imm_d = {{(WIDTH-12){iInst[31]}}, iInst[31:20]};
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      vld_q  <= 1'b0;
      halt_q <= 1'b0;
      bnd_q  <= '0;
      imm_q  <= '0;
    end else begin
      if (accept && !is_halt) begin
        vld_q <= 1'b1;
        bnd_q <= bnd_d;
        imm_q <= imm_d;
      end else if (iReady) begin
        vld_q <= 1'b0;
      end
      if (accept && is_halt) begin
        halt_q <= 1'b1;
      end
    end
  end

  assign oValid     = vld_q;
  assign oHalt      = halt_q;
  assign oRd        = bnd_q.rd;
  assign oRs1       = bnd_q.rs1;
  assign oRs2       = bnd_q.rs2;
  assign oImm       = imm_q;
  assign oAluOp     = bnd_q.alu_op;
  assign oAluSrcImm = bnd_q.alu_src_imm;
  assign oRegWrite  = bnd_q.reg_write;
  assign oIllegal   = bnd_q.illegal;

`ifdef INST_DECODE_PERF_EN
  logic [31:0] inst_cnt_q, stall_cnt_q;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      inst_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept) begin
        inst_cnt_q <= inst_cnt_q + 32'd1;
      end
      if (vld_q && !iReady) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign oInstCount  = inst_cnt_q;
  assign oStallCount = stall_cnt_q;
`else
  assign oInstCount  = '0;
  assign oStallCount = '0;
`endif

endmodule

// File: tb/tb_inst_decode.sv
// Randomized + directed bench for inst_decode against a spec-level decode model.
module tb_inst_decode;

`ifdef INST_DECODE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        src, rw, ill;
  } exp_t;

  logic        iClk = 1'b0;
  logic        iRstN, iValid, iReady;
  logic [31:0] iInst;
  logic        oReady, oValid, oAluSrcImm, oRegWrite, oIllegal, oHalt;
  logic [4:0]  oRd, oRs1, oRs2;
  logic [31:0] oImm, oInstCount, oStallCount;
  logic [3:0]  oAluOp;

  inst_decode #(.WIDTH(32)) dut (
    .iClk(iClk), .iRstN(iRstN), .iInst(iInst), .iValid(iValid), .oReady(oReady),
    .oValid(oValid), .iReady(iReady), .oRd(oRd), .oRs1(oRs1), .oRs2(oRs2),
    .oImm(oImm), .oAluOp(oAluOp), .oAluSrcImm(oAluSrcImm), .oRegWrite(oRegWrite),
    .oIllegal(oIllegal), .oHalt(oHalt), .oInstCount(oInstCount), .oStallCount(oStallCount)
  );

  always #5 iClk = ~iClk;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Decode straight from the ISA tables: mnemonic by funct3, qualified by funct7.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    logic [3:0] base_op [8];
    logic [6:0] opc, f7;
    logic [2:0] f3;
    base_op = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.imm = 32'd0; e.op = 4'd0; e.src = 1'b0; e.ill = 1'b1;
    if (opc == 7'h33) begin
      if (f7 == 7'h00) begin e.ill = 1'b0; e.op = base_op[f3]; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin e.ill = 1'b0; e.op = 4'd1; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin e.ill = 1'b0; e.op = 4'd7; end
    end else if (opc == 7'h13) begin
      e.src = 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        e.imm = {27'd0, w[24:20]};
        if (f7 == 7'h00) begin e.ill = 1'b0; e.op = base_op[f3]; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin e.ill = 1'b0; e.op = 4'd7; end
      end else begin
        e.imm = $signed(w) >>> 20;
        e.ill = 1'b0;
        e.op  = base_op[f3];
      end
    end
    if (e.ill) e.op = 4'd0;
    e.rw = !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  logic        m_vld = 1'b0, m_halt = 1'b0, exp_rdy;
  logic [31:0] m_icnt = 32'd0, m_scnt = 32'd0;
  exp_t        m_b;

  always @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      m_vld <= 1'b0; m_halt <= 1'b0; m_icnt <= 32'd0; m_scnt <= 32'd0;
    end else begin
      logic acc;
      acc = iValid && !m_halt && (!m_vld || iReady);
      if (m_vld && !iReady) m_scnt <= m_scnt + 32'd1;
      if (acc) m_icnt <= m_icnt + 32'd1;
      if (acc && iInst == 32'd0) begin
        m_halt <= 1'b1;
        if (iReady) m_vld <= 1'b0;
      end else if (acc) begin
        m_vld <= 1'b1;
        m_b   <= ref_decode(iInst);
      end else if (iReady) begin
        m_vld <= 1'b0;
      end
    end
  end

  always @(negedge iClk) begin
    if (run_cmp) begin
      exp_rdy = iRstN && !m_halt && (!m_vld || iReady);
      chk("valid", {31'd0, oValid}, {31'd0, m_vld});
      chk("ready", {31'd0, oReady}, {31'd0, exp_rdy});
      chk("halt", {31'd0, oHalt}, {31'd0, m_halt});
      chk("inst_count", oInstCount, PERF ? m_icnt : 32'd0);
      chk("stall_count", oStallCount, PERF ? m_scnt : 32'd0);
      if (m_vld) begin
        chk("rd", {27'd0, oRd}, {27'd0, m_b.rd});
        chk("rs1", {27'd0, oRs1}, {27'd0, m_b.rs1});
        chk("rs2", {27'd0, oRs2}, {27'd0, m_b.rs2});
        chk("imm", oImm, m_b.imm);
        chk("alu_op", {28'd0, oAluOp}, {28'd0, m_b.op});
        chk("alu_src_imm", {31'd0, oAluSrcImm}, {31'd0, m_b.src});
        chk("reg_write", {31'd0, oRegWrite}, {31'd0, m_b.rw});
        chk("illegal", {31'd0, oIllegal}, {31'd0, m_b.ill});
      end
    end
  end

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    iValid = 1'b1; iInst = w;
    step();
    iValid = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  f7;
    int k;
    w = $urandom;
    k = $urandom_range(0, 3);
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    if (k == 0) begin w[6:0] = 7'h33; w[31:25] = f7; end
    else if (k == 1) begin w[6:0] = 7'h13; w[31:25] = f7; end
    else if (k == 2) begin w[6:0] = 7'h13; end
    if (w == 32'd0) w = 32'h13;
    return w;
  endfunction

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, oValid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, oReady}, 32'd0);
    chk({tag, "_halt"}, {31'd0, oHalt}, 32'd0);
    chk({tag, "_fields"}, {12'd0, oRd, oRs1, oRs2, oAluOp, oAluSrcImm, oRegWrite, oIllegal}, 32'd0);
    chk({tag, "_imm"}, oImm, 32'd0);
    chk({tag, "_counts"}, oInstCount | oStallCount, 32'd0);
  endtask

  initial begin
    iRstN = 1'b0; iValid = 1'b0; iReady = 1'b1; iInst = 32'd0;
    repeat (2) step();
    chk_zero_outputs("reset");
    iRstN = 1'b1;
    #1;
    chk("ready_after_reset", {31'd0, oReady}, 32'd1);
    run_cmp = 1'b1;

    send(32'h00A08093);
    chk("addi_valid", {31'd0, oValid}, 32'd1);
    chk("addi_rd_rs1", {22'd0, oRd, oRs1}, {22'd0, 5'd1, 5'd1});
    chk("addi_imm", oImm, 32'h0000000A);
    chk("addi_op_src_rw", {25'd0, oAluOp, oAluSrcImm, oRegWrite, oIllegal}, {25'd0, 4'd0, 3'b110});

    send(32'h40610533);
    chk("sub_regs", {17'd0, oRd, oRs1, oRs2}, {17'd0, 5'd10, 5'd2, 5'd6});
    chk("sub_op_imm", {28'd0, oAluOp} | oImm, 32'd1);
    send(32'h40555693);
    chk("srai_rd_rs1", {22'd0, oRd, oRs1}, {22'd0, 5'd13, 5'd10});
    chk("srai_imm_op", {oImm[27:0], oAluOp}, {28'd5, 4'd7});
    send(32'hFFF08093);
    chk("neg_imm", oImm, 32'hFFFFFFFF);

    send(32'h001101B3);
    iReady = 1'b0; iValid = 1'b1; iInst = 32'h40610533;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_ready", {31'd0, oReady}, 32'd0);
      chk("stall_bundle", {17'd0, oRd, oRs1, oRs2}, {17'd0, 5'd3, 5'd2, 5'd1});
    end
`ifdef INST_DECODE_PERF_EN
    chk("stall_count_3", oStallCount, 32'd3);
`endif
    iReady = 1'b1;
    step();
    iValid = 1'b0;
    chk("b2b_valid_rd", {26'd0, oValid, oRd}, {26'd0, 1'b1, 5'd10});
    chk("b2b_op", {28'd0, oAluOp}, 32'd1);

    send(32'h0000007F);
    chk("illegal_op", {30'd0, oIllegal, oRegWrite}, 32'b10);
    send(32'h00000013);
    chk("x0_dest", {25'd0, oRd, oIllegal, oRegWrite}, 32'd0);
    send(32'h4030A233);
    chk("slt_alt_f7", {31'd0, oIllegal}, 32'd1);

    for (int c = 0; c < 600; c++) begin
      iValid = ($urandom_range(0, 3) != 0);
      iReady = ($urandom_range(0, 3) != 0);
      iInst  = rand_inst();
      step();
    end
    iValid = 1'b0; iReady = 1'b1;
    repeat (2) step();

    iReady = 1'b0;
    send(32'h001101B3);
    step();
    #3 iRstN = 1'b0;
    #1;
    chk_zero_outputs("midstall_reset");
    @(posedge iClk);
    #1 iRstN = 1'b1;
    iReady = 1'b1;
    step();

    iValid = 1'b1; iInst = 32'h00A08093;
    step();
    chk("halt_pre_addi", {26'd0, oValid, oRd}, {26'd0, 1'b1, 5'd1});
    iInst = 32'h00000000;
    step();
    chk("halt_drained", {30'd0, oValid, oHalt}, 32'b01);
    iInst = 32'h00A08093;
    repeat (3) begin
      step();
      chk("halt_ready_low", {31'd0, oReady}, 32'd0);
    end
`ifdef INST_DECODE_PERF_EN
    chk("halt_inst_count", oInstCount, 32'd2);
`endif
    iValid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_decode.md
# inst_decode

Decode stage directly downstream of the instruction ROM/fetch block. Accepts one 32-bit RV32I instruction word per handshake, decodes R-type and I-type ALU instructions into register indices, sign-extended immediate and ALU control, and holds the result in a single-entry pipeline register for the execute stage. It detects the all-zero halt word and illegal encodings, and applies valid/ready backpressure in both directions.

## Interface
- WIDTH, 32, datapath and immediate width.
- iClk  in  1  clock, rising edge.
- iRstN  in  1  asynchronous active-low reset.
- iInst  in  32  instruction word from fetch.
- iValid  in  1  iInst valid.
- oReady  out  1  decode can accept this cycle.
- oValid  out  1  decoded bundle valid.
- iReady  in  1  execute accepts the bundle.
- oRd, oRs1, oRs2  out  5 each  register indices.
- oImm  out  WIDTH  immediate; 0 for R-type.
- oAluOp  out  4  ALU operation code.
- oAluSrcImm  out  1  operand B is oImm.
- oRegWrite  out  1  write rd; 0 when rd==0 or illegal.
- oIllegal  out  1  bundle carries an illegal encoding.
- oHalt  out  1  sticky; halt word consumed.
- oInstCount, oStallCount  out  32 each  performance counters.

## Operation
- Accept: iValid && oReady. oReady = !oHalt && (!oValid || iReady).
- Opcode 0110011 (R): funct7 0000000 with any funct3, or 0100000 with funct3 000 (SUB) / 101 (SRA); anything else is illegal. oAluSrcImm=0.
- Opcode 0010011 (I): oAluSrcImm=1. funct3 001/101 are shifts: oImm = zero-extended inst[24:20]; funct7 must be 0000000 (001, 101) or 0100000 (101 only → SRA), else illegal. Other funct3: oImm = sign-extended inst[31:20].
- iInst == 0x00000000: halt. Consumed, not forwarded (oValid stays 0 for it), oHalt sets.
- Any other opcode: forwarded with oIllegal=1, oRegWrite=0, oAluOp=ADD.
- oAluOp: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9. Opcode 0010011 never yields SUB.
- Whenever oValid=1 && iReady=0, all bundle outputs hold stable.

## Timing
- Latency: bundle valid in the cycle after acceptance. Throughput 1/cycle while iReady=1.
- Reset (async assert, sync to iClk on release): oValid=0, oHalt=0, all bundle fields 0, counters 0. oReady=1 once reset is released.
- Accept and drain in the same cycle: the new bundle replaces the old one, with no bubble.
- Halt word accepted at cycle N: oHalt=1 from N+1 and oReady=0 until reset. A bundle already held in the register still drains normally.
- Reset mid-stall: the held bundle is discarded.

## Configuration
- INST_DECODE_PERF_EN defined: oInstCount increments on every accept, including halt and illegal words. oStallCount increments each cycle oValid && !iReady. Both wrap at 2^32.
- Undefined: no counter flops; both ports tie to 0.

## Structure
- Shared package rv_decode_pkg: opcode constants (OP_R=7'b0110011, OP_I=7'b0010011), funct7 constants, the 4-bit alu_op_t enum, and the decoded-bundle struct.
- One combinational sub-module, alu_ctrl: maps opcode/funct3/funct7 to oAluOp and an illegal flag. It contains no state.

## Test plan
- 0x00A08093 (ADDI): oRd=1, oRs1=1, oImm=0x0000000A, oAluOp=0, oAluSrcImm=1, oRegWrite=1, one cycle after accept.
- 0x40610533 (SUB): rd=10, rs1=2, rs2=6, oAluOp=1, oImm=0. Then 0x40555693 (SRAI): rd=13, rs1=10, oImm=5, oAluOp=7. Then 0xFFF08093: oImm=0xFFFFFFFF.
- Backpressure: accept 0x001101B3, hold iReady=0 for 3 cycles. Bundle stable, oReady=0, oStallCount=3. Then raise iReady with iValid=1: back-to-back transfer with no bubble.
- Illegal and x0 cases: 0x0000007F gives oIllegal=1, oRegWrite=0. 0x00000013 gives rd=0, oRegWrite=0, oIllegal=0. 0x4030A233 (SLT with funct7=0100000) gives oIllegal=1.
- Halt: stream ADDI then 0x00000000. ADDI bundle drains, oHalt=1, oReady stays 0 with iValid=1, and oInstCount=2. Assert iRstN=0 mid-stream: all outputs 0 immediately.
